sec_stopwatch: RTL and testbench
================================

SEC_STOPWATCH -- requirements
Module: sec_stopwatch

Interface
REQ-001 The block SHALL have no parameters; the count range is fixed at 00:00 to 59:59, in BCD.
REQ-002 safe_clk  in  1  1 MHz MMCM cascade clock; all logic on its rising edge.
REQ-003 safe_reset_n  in  1  asynchronous active-low reset; assertion clears state immediately, deassertion is synchronous to safe_clk.
REQ-004 tick_in  in  1  1 s period square wave from the upstream counter stage; synchronous to safe_clk; no synchroniser.
REQ-005 start  in  1  single-cycle command: run or resume.
REQ-006 stop  in  1  single-cycle command: pause.
REQ-007 clear  in  1  single-cycle command: return to 00:00 and IDLE.
REQ-008 sec_bcd  out  8  seconds as BCD: [7:4] tens 0-5, [3:0] ones 0-9.
REQ-009 min_bcd  out  8  minutes as BCD: [7:4] tens 0-5, [3:0] ones 0-9.
REQ-010 running  out  1  high while in state RUN.
REQ-011 tick_seen  out  1  one-cycle pulse, coincident with each count update.
REQ-012 min_wrap  out  1  one-cycle pulse when the count wraps 59:59 -> 00:00.

Function
REQ-013 Edge detect: tick_q SHALL register tick_in; a rise SHALL be tick_in=1 with tick_q=0, sampled at a clock edge.
REQ-014 FSM states SHALL be IDLE, RUN and PAUSE.
REQ-015 Command priority SHALL be clear > stop > start.
REQ-016 IDLE: start -> RUN.
REQ-017 RUN: stop -> PAUSE.
REQ-018 PAUSE: start -> RUN.
REQ-019 clear in any state -> IDLE, with sec_bcd=min_bcd=0x00 at the next edge.
REQ-020 start+stop in the same cycle SHALL cause no transition in IDLE or PAUSE, and RUN -> PAUSE in RUN.
REQ-021 The count SHALL advance only when the state is RUN, a rise is detected, and neither stop nor clear is asserted that cycle.
REQ-022 A rise in the same cycle as start from IDLE or PAUSE SHALL NOT be counted.
REQ-023 Latency: at the edge that samples a counted rise, sec_bcd/min_bcd SHALL update and tick_seen SHALL go high for exactly that following cycle.
REQ-024 Seconds ones SHALL wrap 9 -> 0 and carry into tens.
REQ-025 Seconds 0x59 SHALL wrap to 0x00 and increment minutes by the same BCD rules.
REQ-026 Count 59:59 SHALL wrap to 00:00, pulse min_wrap for one cycle alongside tick_seen, and remain in RUN.
REQ-027 Outputs SHALL be registered and never hold a non-BCD value.

Reset
REQ-028 While safe_reset_n=0: state=IDLE, sec_bcd=0x00, min_bcd=0x00, running=0, tick_seen=0, min_wrap=0, alarm=0.
REQ-029 While safe_reset_n=0, tick_q SHALL be held at 1, so a tick_in held high through reset deassertion yields no rise.
REQ-030 Reset asserted mid-RUN SHALL discard the count immediately, without waiting for a clock edge.

Configuration
REQ-031 Macro SEC_STOPWATCH_ALARM_EN, when defined, SHALL add alarm_min_bcd (in 8), alarm_sec_bcd (in 8) and alarm (out 1).
REQ-032 With SEC_STOPWATCH_ALARM_EN defined, alarm SHALL set on the edge where a counted update makes min_bcd:sec_bcd equal alarm_min_bcd:alarm_sec_bcd.
REQ-033 With SEC_STOPWATCH_ALARM_EN defined, alarm SHALL be sticky until clear or reset.
REQ-034 With SEC_STOPWATCH_ALARM_EN defined, non-BCD alarm values (nibble >9 or tens >5) SHALL never match.
REQ-035 With SEC_STOPWATCH_ALARM_EN defined, an alarm of 00:00 SHALL match only on wrap.
REQ-036 Without SEC_STOPWATCH_ALARM_EN, the three alarm ports and all alarm logic SHALL be absent; all other behaviour is identical.

Verification
REQ-037 Reset release with tick_in=1 held -> no tick_seen, running=0, 00:00; pulse start then 3 rises -> sec_bcd=0x03, 3 tick_seen pulses, running=1.
REQ-038 Start then 10 rises -> sec_bcd 0x09->0x10; 3599 rises -> 59:59; next rise -> 00:00, min_wrap high exactly 1 cycle, running stays 1.
REQ-039 Run to 0x05, stop, 2 rises -> 0x05, running=0; start, next rise -> 0x06.
REQ-040 Simultaneous events: start+stop in IDLE -> stays IDLE; stop+rise in RUN -> count unchanged, PAUSE; clear+rise at 0x12 -> 00:00 IDLE; start+rise from PAUSE -> count unchanged, RUN.
REQ-041 SEC_STOPWATCH_ALARM_EN defined, alarm=00:07: alarm rises with sec_bcd=0x07 and holds through 0x08; clear -> alarm=0. alarm_sec_bcd=0x6A: no match over a full 3600 rises.
REQ-042 Assert safe_reset_n=0 mid-cycle at 12:34 -> all outputs 0 before the next safe_clk edge; release -> IDLE at 00:00.

Source files
------------

// File: rtl/sec_stopwatch.sv
// sec_stopwatch: BCD mm:ss stopwatch (00:00-59:59) with IDLE/RUN/PAUSE control on tick_in rises.
// Optional alarm compare enabled by defining SEC_STOPWATCH_ALARM_EN.
module sec_stopwatch (
    input  logic       safe_clk,
    input  logic       safe_reset_n,
    input  logic       tick_in,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
`ifdef SEC_STOPWATCH_ALARM_EN
    input  logic [7:0] alarm_min_bcd,
    input  logic [7:0] alarm_sec_bcd,
    output logic       alarm,
`endif
    output logic [7:0] sec_bcd,
    output logic [7:0] min_bcd,
    output logic       running,
    output logic       tick_seen,
    output logic       min_wrap
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t     state_q;
    logic       tick_q, adv, sec_wrap, running_q, tick_seen_q, min_wrap_q;
    logic [7:0] sec_q, sec_d, min_q, min_d;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        return v[3:0] == 4'd9 ? {v[7:4] == 4'd5 ? 4'd0 : v[7:4] + 4'd1, 4'd0}
                              : {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        adv      = state_q == RUN && tick_in && !tick_q && !stop && !clear;
        sec_wrap = sec_q == 8'h59;
        sec_d    = clear ? 8'h00 : adv ? (sec_wrap ? 8'h00 : bcd_inc(sec_q)) : sec_q;
        min_d    = clear ? 8'h00 : (adv && sec_wrap) ? (min_q == 8'h59 ? 8'h00 : bcd_inc(min_q)) : min_q;
    end

    // tick_q resets high so a tick_in held through reset release is not a rise
    always_ff @(posedge safe_clk or negedge safe_reset_n) begin
        if (!safe_reset_n) begin
            state_q     <= IDLE;
            tick_q      <= 1'b1;
            sec_q       <= 8'h00;
            min_q       <= 8'h00;
            running_q   <= 1'b0;
            tick_seen_q <= 1'b0;
            min_wrap_q  <= 1'b0;
        end else begin
            tick_q      <= tick_in;
            sec_q       <= sec_d;
            min_q       <= min_d;
            tick_seen_q <= adv;
            min_wrap_q  <= adv && sec_wrap && min_q == 8'h59;
            if (clear) begin
                state_q   <= IDLE;
                running_q <= 1'b0;
            end else if (stop) begin
                if (state_q == RUN) begin
                    state_q   <= PAUSE;
                    running_q <= 1'b0;
                end
            end else if (start) begin
                state_q   <= RUN;
                running_q <= 1'b1;
            end
        end
    end

`ifdef SEC_STOPWATCH_ALARM_EN
    logic alarm_q;
    // the counted value is always BCD, so a non-BCD alarm setting can never compare equal
    always_ff @(posedge safe_clk or negedge safe_reset_n) begin
        if (!safe_reset_n)
            alarm_q <= 1'b0;
        else
            alarm_q <= clear ? 1'b0 : alarm_q | (adv && {min_d, sec_d} == {alarm_min_bcd, alarm_sec_bcd});
    end
    assign alarm = alarm_q;
`endif

    assign sec_bcd   = sec_q;
    assign min_bcd   = min_q;
    assign running   = running_q;
    assign tick_seen = tick_seen_q;
    assign min_wrap  = min_wrap_q;
endmodule

// File: tb/tb_sec_stopwatch.sv
// tb_sec_stopwatch: directed + randomized checks of sec_stopwatch against a seconds-count reference model.
module tb_sec_stopwatch;
    logic       clk = 1'b0, rst_n = 1'b0, tick = 1'b1, start = 1'b0, stop = 1'b0, clear = 1'b0;
    logic [7:0] sec_bcd, min_bcd;
    logic       running, tick_seen, min_wrap;
`ifdef SEC_STOPWATCH_ALARM_EN
    logic [7:0] a_min = 8'h00, a_sec = 8'h00;
    logic       alarm;
`endif

    int n_tests = 0, n_fail = 0;
    int total, mode;
    bit prev, e_tick, e_wrap, e_alarm;

    sec_stopwatch dut (
        .safe_clk(clk), .safe_reset_n(rst_n), .tick_in(tick),
        .start(start), .stop(stop), .clear(clear),
`ifdef SEC_STOPWATCH_ALARM_EN
        .alarm_min_bcd(a_min), .alarm_sec_bcd(a_sec), .alarm(alarm),
`endif
        .sec_bcd(sec_bcd), .min_bcd(min_bcd), .running(running),
        .tick_seen(tick_seen), .min_wrap(min_wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] to_bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

`ifdef SEC_STOPWATCH_ALARM_EN
    function automatic int alarm_target();
        if (a_min[7:4] > 5 || a_min[3:0] > 9 || a_sec[7:4] > 5 || a_sec[3:0] > 9) return -1;
        return (int'(a_min[7:4]) * 10 + int'(a_min[3:0])) * 60 + int'(a_sec[7:4]) * 10 + int'(a_sec[3:0]);
    endfunction
`endif

    task automatic model_reset();
        total = 0; mode = 0; prev = 1'b1; e_tick = 0; e_wrap = 0; e_alarm = 0;
    endtask

    task automatic check_all();
        check("sec_bcd", sec_bcd, to_bcd(total % 60));
        check("min_bcd", min_bcd, to_bcd(total / 60));
        check("running", running, mode == 1);
        check("tick_seen", tick_seen, e_tick);
        check("min_wrap", min_wrap, e_wrap);
`ifdef SEC_STOPWATCH_ALARM_EN
        check("alarm", alarm, e_alarm);
`endif
    endtask

    // mode: 0 idle, 1 run, 2 pause; total is elapsed seconds modulo one hour
    task automatic cycle();
        bit rise, cnt;
        @(posedge clk);
        rise = tick && !prev;
        prev = tick;
        cnt = mode == 1 && rise && !stop && !clear;
        e_tick = cnt;
        e_wrap = cnt && total == 3599;
        if (cnt) total = (total + 1) % 3600;
        if (clear) total = 0;
`ifdef SEC_STOPWATCH_ALARM_EN
        if (clear) e_alarm = 0;
        else if (cnt && total == alarm_target()) e_alarm = 1;
`endif
        if (clear) mode = 0;
        else if (stop) mode = mode == 1 ? 2 : mode;
        else if (start) mode = 1;
        #1 check_all();
    endtask

    task automatic cmd(input bit st, input bit sp, input bit cl, input bit tk);
        start = st; stop = sp; clear = cl; tick = tk;
        cycle();
        start = 0; stop = 0; clear = 0;
    endtask

    task automatic rise_n(input int n);
        repeat (n) begin
            cmd(0, 0, 0, 0);
            cmd(0, 0, 0, 1);
        end
    endtask

    task automatic reset_mid();
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("rst_sec", sec_bcd, 8'h00);
        check("rst_min", min_bcd, 8'h00);
        check("rst_running", running, 1'b0);
        check("rst_tick_seen", tick_seen, 1'b0);
        check("rst_min_wrap", min_wrap, 1'b0);
`ifdef SEC_STOPWATCH_ALARM_EN
        check("rst_alarm", alarm, 1'b0);
`endif
        model_reset();
        @(negedge clk) rst_n = 1;
    endtask

    initial begin
        model_reset();
        #12 check_all();
        @(negedge clk) rst_n = 1;
        repeat (3) cmd(0, 0, 0, 1);
        cmd(1, 0, 0, 1);
        rise_n(3);
        check("start3_sec", sec_bcd, 8'h03);
        check("start3_run", running, 1'b1);

        cmd(0, 0, 1, 0);
        cmd(1, 0, 0, 0);
        rise_n(10);
        check("ten_sec", sec_bcd, 8'h10);
        rise_n(3589);
        check("full_min", min_bcd, 8'h59);
        check("full_sec", sec_bcd, 8'h59);
        rise_n(1);
        check("wrap_pulse", min_wrap, 1'b1);
        cmd(0, 0, 0, 1);
        check("wrap_once", min_wrap, 1'b0);
        check("wrap_run", running, 1'b1);

        cmd(0, 0, 1, 0);
        cmd(1, 0, 0, 0);
        rise_n(5);
        cmd(0, 1, 0, 0);
        rise_n(2);
        check("pause_sec", sec_bcd, 8'h05);
        check("pause_run", running, 1'b0);
        cmd(1, 0, 0, 0);
        rise_n(1);
        check("resume_sec", sec_bcd, 8'h06);

        cmd(0, 0, 1, 0);
        cmd(1, 1, 0, 0);
        check("ss_idle", running, 1'b0);
        cmd(1, 0, 0, 0);
        rise_n(12);
        cmd(0, 0, 0, 0);
        cmd(0, 1, 0, 1);
        check("stop_rise_sec", sec_bcd, 8'h12);
        cmd(1, 0, 0, 0);
        cmd(0, 0, 0, 0);
        cmd(0, 0, 1, 1);
        check("clear_rise_sec", sec_bcd, 8'h00);
        cmd(1, 0, 0, 0);
        rise_n(2);
        cmd(0, 1, 0, 0);
        cmd(0, 0, 0, 0);
        cmd(1, 0, 0, 1);
        check("start_rise_sec", sec_bcd, 8'h02);
        check("start_rise_run", running, 1'b1);

`ifdef SEC_STOPWATCH_ALARM_EN
        a_min = 8'h00; a_sec = 8'h07;
        cmd(0, 0, 1, 0);
        cmd(1, 0, 0, 0);
        rise_n(7);
        check("alarm_set", alarm, 1'b1);
        rise_n(1);
        check("alarm_hold", alarm, 1'b1);
        cmd(0, 0, 1, 0);
        a_sec = 8'h6A;
        cmd(1, 0, 0, 0);
        rise_n(3600);
        a_min = 8'h00; a_sec = 8'h00;
`endif

        repeat (4000)
            cmd($urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                $urandom_range(0, 63) == 0, 1'($urandom_range(0, 1)));

        cmd(0, 0, 1, 0);
        cmd(1, 0, 0, 0);
        rise_n(754);
        check("at_1234_min", min_bcd, 8'h12);
        check("at_1234_sec", sec_bcd, 8'h34);
        reset_mid();
        repeat (3) cmd(0, 0, 0, 1);
        check("post_rst_sec", sec_bcd, 8'h00);
        check("post_rst_run", running, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
